ram_arb: RTL
============

Name: ram_arb

Overview:
- Shares the single-port data RAM between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Arbitrates requests with a req/gnt handshake and issues exactly one RAM access per grant.
- Sequences the one-cycle RAM read latency and returns read data through a per-requester one-entry response buffer with rvalid/rready.
- Sits between the IFU/LSU stage outputs and the RAM model's rd/wr ports.

Parameters:
- ADDR_WIDTH, 32, RAM byte-address width.
- DATA_WIDTH, 32, RAM data width; must be a multiple of 8.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ifu_req  in  1  IFU read request; held until granted.
- i_ifu_addr  in  ADDR_WIDTH  IFU read address.
- o_ifu_gnt  out  1  IFU request accepted this cycle.
- o_ifu_rvalid  out  1  IFU read data valid.
- o_ifu_rdata  out  DATA_WIDTH  IFU read data.
- i_ifu_rready  in  1  IFU consumes response.
- i_lsu_req  in  1  LSU request; held until granted.
- i_lsu_we  in  1  1 = write, 0 = read.
- i_lsu_addr  in  ADDR_WIDTH  LSU address.
- i_lsu_wdata  in  DATA_WIDTH  LSU write data.
- i_lsu_wmask  in  DATA_WIDTH/8  LSU byte write mask.
- o_lsu_gnt  out  1  LSU request accepted this cycle.
- o_lsu_rvalid  out  1  LSU read data valid.
- o_lsu_rdata  out  DATA_WIDTH  LSU read data.
- i_lsu_rready  in  1  LSU consumes response.
- o_ram_rd_en  out  1  RAM read enable.
- o_ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- i_ram_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after o_ram_rd_en.
- o_ram_wr_en  out  1  RAM write enable.
- o_ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- o_ram_wr_data  out  DATA_WIDTH  RAM write data.
- o_ram_wr_mask  out  DATA_WIDTH/8  RAM byte write mask.

Behaviour:
- Reset: state IDLE, both response buffers empty.
  - All outputs 0: gnt, rvalid, rdata, and every RAM output.
  - Takes effect asynchronously. An in-flight read is discarded; no rvalid is produced for it.
- FSM states: IDLE, RD.
  - IDLE -> RD on a granted read.
  - RD -> IDLE unconditionally.
  - A granted write stays in IDLE.
- Eligibility: a requester is eligible only when state is IDLE, its req is 1, and its response buffer is empty (rvalid=0).
  - LSU writes also require the LSU buffer to be empty, which keeps LSU ordering.
- Grant: o_*_gnt is combinational; at most one gnt per cycle; never asserted in RD.
- RAM drive in the grant cycle (combinational, from the granted requester's inputs):
  - Read: rd_en=1, rd_addr=addr.
  - Write: wr_en=1, wr_addr/wr_data/wr_mask driven from LSU inputs.
  - RAM outputs are 0 when there is no grant.
- In RD: i_ram_rd_data is captured into the granted requester's buffer at the RD clock edge.
- Read latency: rvalid rises 2 cycles after gnt. Example: gnt in cycle N, RAM data in cycle N+1, rvalid=1 in cycle N+2.
  - rvalid/rdata stay stable until rvalid & rready; the buffer empties on that edge.
  - A new grant to the same requester is possible in the same cycle the buffer empties only if rready is high (combinational eligibility uses the pop).
- Throughput: reads 1 per 2 cycles; writes 1 per cycle. A write cannot follow a read before RD completes.
- Simultaneous eligible requests: LSU wins (fixed priority). Ineligible requesters are ignored, never stalled on.
- Write response: none; a write is complete at gnt.
- Requester protocol: addr/we/wdata/wmask must be stable while req=1 and gnt=0. Dropping req before gnt is legal; no access is issued.

Optional Feature:
- RAM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant register (reset = IFU) gives the other requester priority on the next contest; it updates on every gnt.
- RAM_ARB_RR_EN undefined: fixed LSU > IFU priority; the register is not instantiated.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum ram_arb_state_e {IDLE, RD}.
  - typedef enum ram_arb_id_e {ID_IFU, ID_LSU}.
  - localparam ID_RST = ID_IFU.
- Sub-module ram_arb_resp_buf: one-entry buffer with push/data_in/rvalid/rdata/rready. Instantiated once per requester.

Test Plan:
- IFU-only read: i_ifu_addr=0x100, RAM returns 0xDEADBEEF. Required: gnt cycle 0, rd_en=1 with rd_addr=0x100 in cycle 0, rvalid=1 with rdata=0xDEADBEEF in cycle 2, rvalid held while rready=0, cleared after the rready handshake.
- LSU write: addr=0x200, wdata=0x12345678, wmask=4'b0011. Required: same-cycle gnt with wr_en=1 and all fields matching; the following write is granted the next cycle (1 write/cycle).
- Simultaneous reads: both requesters request in cycle 0. Fixed priority: LSU granted cycle 0, IFU granted cycle 2. With RAM_ARB_RR_EN, a second contest grants the opposite requester from the first.
- Buffer full: LSU rvalid=1 with rready=0 while LSU req is pending and IFU requests. Required: IFU granted, LSU not granted until the cycle rready=1.
- Reset mid-read: i_rst_n=0 in the RD cycle. Required: all outputs 0 immediately; no rvalid after release; a new request after release is served normally.
- Req withdrawn: IFU req pulses 1 cycle while the LSU is granted. Required: no IFU gnt, no IFU RAM access.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the IFU/LSU data-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {IDLE, RD} ram_arb_state_e;

  typedef enum logic {ID_IFU, ID_LSU} ram_arb_id_e;

  localparam ram_arb_id_e ID_RST = ID_IFU;

endpackage

// File: rtl/ram_arb_resp_buf.sv
// One-entry read response buffer; filled by the arbiter, drained by rvalid/rready.
module ram_arb_resp_buf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  rready_i
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && rready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign rvalid_o = valid_q;
  assign rdata_o  = data_q;

endmodule

// File: rtl/ram_arb.sv
// Single-port data RAM arbiter between IFU (read) and LSU (read/write).
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed LSU > IFU priority.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ifu_req,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
  output logic                    o_ifu_gnt,
  output logic                    o_ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   o_ifu_rdata,
  input  logic                    i_ifu_rready,
  input  logic                    i_lsu_req,
  input  logic                    i_lsu_we,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_wmask,
  output logic                    o_lsu_gnt,
  output logic                    o_lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   o_lsu_rdata,
  input  logic                    i_lsu_rready,
  output logic                    o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
  output logic                    o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask
);

  ram_arb_state_e state_q;
  ram_arb_id_e    rd_id_q;

  logic idle, ifu_elig, lsu_elig, ifu_gnt, lsu_gnt, lsu_rd;
  logic ifu_rvalid, lsu_rvalid, ifu_push, lsu_push;

`ifdef RAM_ARB_RR_EN
  ram_arb_id_e last_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= ID_RST;
    end else if (ifu_gnt || lsu_gnt) begin
      last_q <= lsu_gnt ? ID_LSU : ID_IFU;
    end
  end
`endif

  always_comb begin
    // Reset gates grants so every output is 0 while i_rst_n is low.
    idle     = i_rst_n && (state_q == IDLE);
    // A buffer being drained this cycle counts as empty.
    ifu_elig = idle && i_ifu_req && (!ifu_rvalid || i_ifu_rready);
    lsu_elig = idle && i_lsu_req && (!lsu_rvalid || i_lsu_rready);
`ifdef RAM_ARB_RR_EN
    lsu_gnt  = lsu_elig && (!ifu_elig || (last_q == ID_IFU));
`else
    lsu_gnt  = lsu_elig;
`endif
    ifu_gnt  = ifu_elig && !lsu_gnt;
    lsu_rd   = lsu_gnt && !i_lsu_we;

    o_ifu_gnt     = ifu_gnt;
    o_lsu_gnt     = lsu_gnt;
    o_ram_rd_en   = ifu_gnt || lsu_rd;
    o_ram_rd_addr = ifu_gnt ? i_ifu_addr : (lsu_rd ? i_lsu_addr : '0);
    o_ram_wr_en   = lsu_gnt && i_lsu_we;
    o_ram_wr_addr = o_ram_wr_en ? i_lsu_addr  : '0;
    o_ram_wr_data = o_ram_wr_en ? i_lsu_wdata : '0;
    o_ram_wr_mask = o_ram_wr_en ? i_lsu_wmask : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rd_id_q <= ID_RST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (o_ram_rd_en) begin
            state_q <= RD;
            rd_id_q <= lsu_rd ? ID_LSU : ID_IFU;
          end
        end
        RD: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_push = (state_q == RD) && (rd_id_q == ID_IFU);
  assign lsu_push = (state_q == RD) && (rd_id_q == ID_LSU);

  ram_arb_resp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ifu_buf (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (ifu_push),
    .data_i  (i_ram_rd_data),
    .rvalid_o(ifu_rvalid),
    .rdata_o (o_ifu_rdata),
    .rready_i(i_ifu_rready)
  );

  ram_arb_resp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lsu_buf (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (lsu_push),
    .data_i  (i_ram_rd_data),
    .rvalid_o(lsu_rvalid),
    .rdata_o (o_lsu_rdata),
    .rready_i(i_lsu_rready)
  );

  assign o_ifu_rvalid = ifu_rvalid;
  assign o_lsu_rvalid = lsu_rvalid;

endmodule
